// File: rtl/debounce_sync_pkg.sv
// debounce_sync_pkg: shared state encodings, default sizing
// and elaboration-time configuration checks for debounce_sync.
package debounce_sync_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_e;

  localparam int DEB_CYCLES_DEF = 50000;
  localparam int CNT_W_DEF      = 16;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;

  function automatic bit deb_stages_ok(
    input int stages
  );
    return (stages >= SYNC_MIN) &&
           (stages <= SYNC_MAX);
  endfunction

  // The counter must hold DEBOUNCE_CYCLES
  // without wrapping.
  function automatic bit deb_cycles_ok(
    input int cnt_w,
    input int cycles
  );
    longint lim;
    if (cnt_w < 1) return 1'b0;
    if (cycles < 1) return 1'b0;
    if (cnt_w >= 32) return 1'b1;
    lim = (longint'(1) << cnt_w) - 1;
    return longint'(cycles) <= lim;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: STAGES-deep flop shift chain bringing an
// asynchronous level into the clk domain.
// Ports: clk, rst (async active-low), d (async in),
//        q (synchronised out, last stage).
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff_q <= {STAGES{RESET_VAL}};
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronise a bouncy async input, then
// only pass a new level once it has held for
// DEBOUNCE_CYCLES+1 consecutive synchronised samples.
// Ports: clk, rst (async active-low), din (raw input),
//        q (debounced level), busy (change being timed),
//        rise/fall (1-cycle edge pulses, only when
//        DEB_PULSE_EN is defined).
module debounce_sync
  import debounce_sync_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   CNT_W           = CNT_W_DEF,
  parameter int   DEBOUNCE_CYCLES = DEB_CYCLES_DEF,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic busy
`ifdef DEB_PULSE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  if (!deb_stages_ok(SYNC_STAGES)) begin : g_bad_stages
    $error("debounce_sync: SYNC_STAGES out of 2..4");
  end

  if (!deb_cycles_ok(CNT_W, DEBOUNCE_CYCLES))
  begin : g_bad_cycles
    $error("debounce_sync: DEBOUNCE_CYCLES illegal");
  end

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  logic s;

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      q_q     <= RESET_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  // cnt counts cycles s has disagreed with q; it is
  // cleared whenever s agrees again, so it never
  // exceeds CNT_MAX.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    q_d     = q_q;
    unique case (state_q)
      ST_STABLE: begin
        if (s != q_q) begin
          state_d = ST_PENDING;
          cnt_d   = CNT_ONE;
        end
      end
      ST_PENDING: begin
        if (s == q_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_STABLE;
          q_d     = s;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
      end
    endcase
  end

  assign q    = q_q;
  assign busy = (state_q == ST_PENDING);

`ifdef DEB_PULSE_EN
  logic rise_q, fall_q;

  // Registered from q_d so the pulse lines up with
  // the cycle q takes its new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= q_d & ~q_q;
      fall_q <= ~q_d & q_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed table, corner sequences and
// random stimulus against a sample-history reference model.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;

  always #5 clk = ~clk;

  logic q4, b4, q1, b1;
`ifdef DEB_PULSE_EN
  logic r4, f4, r1, f1;
`endif

  debounce_sync #(
    .SYNC_STAGES     (2),
    .CNT_W           (16),
    .DEBOUNCE_CYCLES (4),
    .RESET_VAL       (1'b0)
  ) u_d4 (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .q    (q4),
    .busy (b4)
`ifdef DEB_PULSE_EN
    ,
    .rise (r4),
    .fall (f4)
`endif
  );

  debounce_sync #(
    .SYNC_STAGES     (2),
    .CNT_W           (16),
    .DEBOUNCE_CYCLES (1),
    .RESET_VAL       (1'b0)
  ) u_d1 (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .q    (q1),
    .busy (b1)
`ifdef DEB_PULSE_EN
    ,
    .rise (r1),
    .fall (f1)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic act,
                     input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm,
                      input int act,
                      input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  // Reference model: q flips to s once the last
  // D+1 synchronised samples all differ from q.
  // busy = at least one trailing sample differs.
  bit dq[$];
  bit sh[8];
  int nsv;
  bit mq[2], mb[2], mr[2], mf[2];

  function automatic int dcyc(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int trail(input bit qv);
    int n = 0;
    while (n < nsv && n < 8 && sh[n] != qv) n++;
    return n;
  endfunction

  task automatic mdl_reset();
    dq.delete();
    dq.push_back(1'b0);
    dq.push_back(1'b0);
    nsv = 0;
    for (int d = 0; d < 2; d++) begin
      mq[d] = 1'b0;
      mb[d] = 1'b0;
      mr[d] = 1'b0;
      mf[d] = 1'b0;
    end
  endtask

  task automatic mdl_edge();
    bit s;
    s = dq.pop_front();
    dq.push_back(din);
    for (int i = 7; i > 0; i--) sh[i] = sh[i-1];
    sh[0] = s;
    if (nsv < 8) nsv++;
    for (int d = 0; d < 2; d++) begin
      mr[d] = 1'b0;
      mf[d] = 1'b0;
      if (trail(mq[d]) >= dcyc(d) + 1) begin
        mr[d] = s & ~mq[d];
        mf[d] = ~s & mq[d];
        mq[d] = s;
      end
      mb[d] = trail(mq[d]) > 0;
    end
  endtask

  task automatic mdl_cmp();
    chk("q4", q4, mq[0]);
    chk("busy4", b4, mb[0]);
    chk("q1", q1, mq[1]);
    chk("busy1", b1, mb[1]);
`ifdef DEB_PULSE_EN
    chk("rise4", r4, mr[0]);
    chk("fall4", f4, mf[0]);
    chk("rise1", r1, mr[1]);
    chk("fall1", f1, mf[1]);
`endif
  endtask

  // One clock: model steps on the edge, outputs
  // checked on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst) mdl_edge();
    @(negedge clk);
    mdl_cmp();
  endtask

  task automatic rst_on();
    rst = 1'b0;
    mdl_reset();
    #1;
    mdl_cmp();
  endtask

  typedef struct {
    logic din;
    logic eq;
    logic eb;
    logic er;
    logic ef;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int   hold;
    int   nchg;
    int   chg_at;
    logic prevq;
    logic qbad, saw, pbad;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    mdl_reset();
    #2;
    rst_on();

    // 1: reset with din=1, then release
    din = 1'b1;
    cyc();
    cyc();
    chk("t1_rst_q", q4, 1'b0);
    chk("t1_rst_busy", b4, 1'b0);
    rst = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      chk("t1_q4_lat", q4, c >= 7);
      chk("t1_q1_lat", q1, c >= 4);
    end

    // 2: table, clean rise then clean fall
    rst_on();
    din = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    repeat (3) cyc();
    for (int i = 0; i < 20; i++) begin
      din = tbl[i].din;
      cyc();
      chk("t2_q", q4, tbl[i].eq);
      chk("t2_busy", b4, tbl[i].eb);
`ifdef DEB_PULSE_EN
      chk("t2_rise", r4, tbl[i].er);
      chk("t2_fall", f4, tbl[i].ef);
`endif
    end

    // 3: 2-cycle low glitch while q=1
    din = 1'b1;
    repeat (8) cyc();
    qbad = 1'b0;
    saw  = 1'b0;
    pbad = 1'b0;
    for (int i = 0; i < 14; i++) begin
      din = (i < 2) ? 1'b0 : 1'b1;
      cyc();
      if (q4 !== 1'b1) qbad = 1'b1;
      if (b4 === 1'b1) saw = 1'b1;
`ifdef DEB_PULSE_EN
      if (f4 !== 1'b0) pbad = 1'b1;
`endif
    end
    chk("t3_q_held", qbad, 1'b0);
    chk("t3_busy_seen", saw, 1'b1);
    chk("t3_busy_end", b4, 1'b0);
    chk("t3_no_fall", pbad, 1'b0);

    // 4: bounce 20 cycles, then settle low
    nchg   = 0;
    chg_at = -1;
    prevq  = q4;
    for (int i = 0; i < 20; i++) begin
      din = ~din;
      cyc();
      if (q4 !== prevq) nchg++;
      prevq = q4;
    end
    din = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (q4 !== prevq) begin
        nchg++;
        chg_at = c;
      end
      prevq = q4;
    end
    chki("t4_changes", nchg, 1);
    chki("t4_chg_cycle", chg_at, 7);
    chk("t4_q_final", q4, 1'b0);

    // 5: reset while pending with cnt=3
    din = 1'b1;
    repeat (5) cyc();
    chk("t5_busy_pre", b4, 1'b1);
    rst_on();
    chk("t5_q_async", q4, 1'b0);
    chk("t5_busy_async", b4, 1'b0);
    cyc();
    cyc();
    rst = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      chk("t5_q_fresh", q4, c >= 7);
`ifdef DEB_PULSE_EN
      chk("t5_rise_fresh", r4, c == 7);
`endif
    end

    // reset during a pending fall: q back to 0 at once
    din = 1'b0;
    repeat (4) cyc();
    chk("t5b_busy_pre", b4, 1'b1);
    chk("t5b_q_pre", q4, 1'b1);
    rst_on();
    chk("t5b_q_async", q4, 1'b0);
    cyc();
    rst = 1'b1;

    // random stimulus with occasional resets
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_on();
        repeat ($urandom_range(1, 3)) cyc();
        rst = 1'b1;
      end else begin
        if (hold == 0) begin
          din  = 1'($urandom);
          hold = $urandom_range(1, 9);
        end
        hold--;
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
